wired_ex_div_arbiter: RTL

- Shares the single iterative divider (`wired_ex_divider`) between `NUM_PORTS` MDU issue ports.
- Grants one request at a time using round-robin priority and records which port owns the in-flight division.
- Routes the divider response back to the owning port and handles pipeline flush.
- Sits between the MDU issue queues and the divider; it adds zero cycles of latency in either direction.

---
 rtl/iq_mdu_pkg.sv | 19 +
 rtl/wired_ex_div_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/iq_mdu_pkg.sv
// Request/response types exchanged between the MDU issue queues and the
// iterative divider.
//   iq_mdu_req_t  : op (0 sdiv, 1 udiv, 2 srem, 3 urem), wid, r0 (divisor), r1 (dividend)
//   iq_mdu_resp_t : wid echoed from the request, 32-bit result
package iq_mdu_pkg;

  typedef struct packed {
    logic [2:0]  op;
    logic [5:0]  wid;
    logic [31:0] r0;
    logic [31:0] r1;
  } iq_mdu_req_t;

  typedef struct packed {
    logic [5:0]  wid;
    logic [31:0] result;
  } iq_mdu_resp_t;

endpackage

// File: rtl/wired_ex_div_arbiter.sv
// Shares one iterative divider between NUM_PORTS MDU issue ports.
// Round-robin grant, single division in flight, response routed back to
// the owning port. Request and response paths are purely combinational.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush_i                   pipeline flush (drops issue and response)
//   req_valid_i/req_ready_o   per-port request handshake, req_i payload
//   div_valid_o/div_ready_i   issue handshake to divider, div_req_o payload
//   div_valid_i/div_ready_o   result handshake from divider, div_resp_i payload
//   resp_valid_o/resp_ready_i per-port result handshake, resp_o broadcast
//   perf_busy_o               cycles spent in BUSY (wraps)
//   perf_grant_o              per-port grant counters (saturating)
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | no division in flight; divider output drained
// ST_BUSY | one division in flight, owned by port owner_q
module wired_ex_div_arbiter
  import iq_mdu_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PTR_W     = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush_i,
  input  logic         [NUM_PORTS-1:0]    req_valid_i,
  output logic         [NUM_PORTS-1:0]    req_ready_o,
  input  iq_mdu_req_t  [NUM_PORTS-1:0]    req_i,
  output logic                            div_valid_o,
  input  logic                            div_ready_i,
  output iq_mdu_req_t                     div_req_o,
  input  logic                            div_valid_i,
  output logic                            div_ready_o,
  input  iq_mdu_resp_t                    div_resp_i,
  output logic         [NUM_PORTS-1:0]    resp_valid_o,
  input  logic         [NUM_PORTS-1:0]    resp_ready_i,
  output iq_mdu_resp_t                    resp_o,
  output logic         [31:0]             perf_busy_o,
  output logic         [NUM_PORTS-1:0][15:0] perf_grant_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                       state_q, state_d;
  logic [PTR_W-1:0]             owner_q, owner_d;
  logic [PTR_W-1:0]             rr_q, rr_d;
  logic [31:0]                  busy_cnt_q, busy_cnt_d;
  logic [NUM_PORTS-1:0][15:0]   grant_cnt_q, grant_cnt_d;

  logic [NUM_PORTS-1:0] gnt;
  logic [PTR_W-1:0]     gnt_idx;
  logic                 found;
  logic                 busy;
  logic                 owner_rdy;
  logic                 resp_hs;
  logic                 can_issue;
  logic                 issue_hs;

  // Round-robin search starting at rr_q.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] p;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (int'(rr_q) + i) % NUM_PORTS;
      p   = PTR_W'(idx);
      if (!found && req_valid_i[p]) begin
        found      = 1'b1;
        gnt[p]     = 1'b1;
        gnt_idx    = p;
      end
    end
  end

  always_comb begin
    busy      = (state_q == ST_BUSY);
    owner_rdy = resp_ready_i[owner_q];
    // resp_hs ignores flush here; flush overrides it in every use below.
    resp_hs   = busy && div_valid_i && owner_rdy;
    can_issue = !flush_i && (!busy || resp_hs);

    div_valid_o = found && can_issue;
    div_req_o   = req_i[gnt_idx];
    req_ready_o = gnt & {NUM_PORTS{can_issue && div_ready_i}};
    issue_hs    = div_valid_o && div_ready_i;

    resp_o       = div_resp_i;
    resp_valid_o = '0;
    if (busy && !flush_i) begin
      resp_valid_o[owner_q] = div_valid_i;
    end
    // Ready stays high outside an owned response so stale results drain.
    div_ready_o = (busy && !flush_i) ? owner_rdy : 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    grant_cnt_d = grant_cnt_q;
    busy_cnt_d  = busy ? busy_cnt_q + 32'd1 : busy_cnt_q;

    if (flush_i) begin
      state_d = ST_IDLE;
    end else if (issue_hs) begin
      state_d = ST_BUSY;
      owner_d = gnt_idx;
      rr_d    = (gnt_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
      if (grant_cnt_q[gnt_idx] != 16'hFFFF) begin
        grant_cnt_d[gnt_idx] = grant_cnt_q[gnt_idx] + 16'd1;
      end
    end else if (resp_hs) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rr_q        <= '0;
      busy_cnt_q  <= '0;
      grant_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      busy_cnt_q  <= busy_cnt_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign perf_busy_o  = busy_cnt_q;
  assign perf_grant_o = grant_cnt_q;

endmodule
